// File: rtl/uart_cmd_decoder.sv
// Byte-level UART command decoder: turns write/read command frames into
// single-cycle register-file strobes and returns read data to the TX FIFO.
module uart_cmd_decoder #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  parity_error,
  input  logic                  framing_error,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_valid,
  input  logic                  fifo_full,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_wr,
  output logic [7:0]            err_cnt,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_REQ, RD_WAIT, RD_SEND
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic                    tx_wr_q, tx_wr_d;
  logic                    busy_q;
  logic                    good, bad, err_inc;

  assign good = rx_valid & ~parity_error & ~framing_error;
  assign bad  = rx_valid & (parity_error | framing_error);

  // Strobes are computed one cycle ahead so every output leaves a flop.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_wr_d   = 1'b0;
    err_inc   = 1'b0;

    if (bad) begin
      state_d = IDLE;
      err_inc = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (good) begin
            if (rx_data == WR_CMD)      state_d = WR_ADDR;
            else if (rx_data == RD_CMD) state_d = RD_ADDR;
            else                        err_inc = 1'b1;
          end
        end
        WR_ADDR: begin
          if (good) begin
            addr_d  = rx_data[ADDR_WIDTH-1:0];
            state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          if (good) begin
            wr_data_d = rx_data;
            wr_en_d   = 1'b1;
            state_d   = WR_EXEC;
          end
        end
        WR_EXEC: begin
          err_inc = good;
          state_d = IDLE;
        end
        RD_ADDR: begin
          if (good) begin
            addr_d  = rx_data[ADDR_WIDTH-1:0];
            rd_en_d = 1'b1;
            state_d = RD_REQ;
          end
        end
        RD_REQ: begin
          err_inc = good;
          state_d = RD_WAIT;
        end
        RD_WAIT: begin
          err_inc = good;
          if (rd_data_valid) begin
            tx_data_d = rd_data;
            state_d   = RD_SEND;
          end
        end
        RD_SEND: begin
          err_inc = good;
          if (!fifo_full) begin
            tx_wr_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      err_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      err_cnt_q <= err_cnt_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_wr_q   <= tx_wr_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;
  assign addr    = addr_q;
  assign wr_data = wr_data_q;
  assign tx_data = tx_data_q;
  assign tx_wr   = tx_wr_q;
  assign err_cnt = err_cnt_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized bench for uart_cmd_decoder with a frame-buffer reference model
// and a simple register-file / TX-FIFO responder.
module tb_uart_cmd_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] rx_data;
  logic       rx_valid, parity_error, framing_error;
  logic [7:0] rd_data;
  logic       rd_data_valid, fifo_full;
  logic       wr_en, rd_en, tx_wr, busy;
  logic [3:0] addr;
  logic [7:0] wr_data, tx_data, err_cnt;

  uart_cmd_decoder dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_error(parity_error), .framing_error(framing_error),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .fifo_full(fifo_full),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .tx_data(tx_data), .tx_wr(tx_wr), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: bytes of the frame being collected, plus the post-frame phase.
  localparam int PH_COLLECT = 0, PH_WSTB = 1, PH_RSTB = 2, PH_WAIT = 3, PH_SEND = 4;
  byte unsigned m_q[$];
  int m_ph, m_addr, m_wdata, m_tx, m_err;
  bit m_wr, m_rd, m_txwr;

  task automatic model_reset();
    m_q.delete();
    m_ph = PH_COLLECT;
    m_addr = 0; m_wdata = 0; m_tx = 0; m_err = 0;
    m_wr = 0; m_rd = 0; m_txwr = 0;
  endtask

  task automatic model_step();
    bit good, bad, inc;
    if (!RST) begin
      model_reset();
      return;
    end
    good = rx_valid && !parity_error && !framing_error;
    bad  = rx_valid && (parity_error || framing_error);
    m_wr = 0; m_rd = 0; m_txwr = 0; inc = 0;
    if (bad) begin
      inc = 1;
      m_q.delete();
      m_ph = PH_COLLECT;
    end else begin
      case (m_ph)
        PH_COLLECT: if (good) begin
          if (m_q.size() == 0 && rx_data != 8'hAA && rx_data != 8'hBB) inc = 1;
          else begin
            m_q.push_back(rx_data);
            if (m_q.size() == 2) m_addr = int'(rx_data) % 16;
            if (m_q[0] == 8'hAA && m_q.size() == 3) begin
              m_wdata = int'(rx_data); m_wr = 1; m_ph = PH_WSTB; m_q.delete();
            end else if (m_q[0] == 8'hBB && m_q.size() == 2) begin
              m_rd = 1; m_ph = PH_RSTB; m_q.delete();
            end
          end
        end
        PH_WSTB: begin inc = good; m_ph = PH_COLLECT; end
        PH_RSTB: begin inc = good; m_ph = PH_WAIT; end
        PH_WAIT: begin
          inc = good;
          if (rd_data_valid) begin m_tx = int'(rd_data); m_ph = PH_SEND; end
        end
        default: begin
          inc = good;
          if (!fifo_full) begin m_txwr = 1; m_ph = PH_COLLECT; end
        end
      endcase
    end
    if (inc && m_err < 255) m_err++;
  endtask

  task automatic compare_all();
    bit m_busy;
    m_busy = (m_ph != PH_COLLECT) || (m_q.size() > 0);
    chk("wr_en",   32'(wr_en),   32'(m_wr));
    chk("rd_en",   32'(rd_en),   32'(m_rd));
    chk("tx_wr",   32'(tx_wr),   32'(m_txwr));
    chk("addr",    32'(addr),    m_addr);
    chk("wr_data", 32'(wr_data), m_wdata);
    chk("tx_data", 32'(tx_data), m_tx);
    chk("err_cnt", 32'(err_cnt), m_err);
    chk("busy",    32'(busy),    32'(m_busy));
  endtask

  // Register-file / FIFO responder settings.
  int  rd_lat = 3, rcnt = 0, ff_len = 0, fcnt = 0, dv_cyc = 0;
  bit  rand_full = 0, spurious = 0, fixed_ret = 0;
  logic [7:0] ret_val = 8'h00;

  task automatic respond();
    rd_data_valid = 1'b0;
    if (rd_en) rcnt = rd_lat;
    else if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        rd_data_valid = 1'b1;
        rd_data = fixed_ret ? ret_val : 8'($urandom);
        dv_cyc = cyc;
        if (ff_len > 0) fcnt = ff_len;
      end
    end
    if (spurious && $urandom_range(0, 15) == 0) begin
      rd_data_valid = 1'b1;
      rd_data = 8'($urandom);
    end
    if (fcnt > 0) begin
      fifo_full = 1'b1;
      fcnt--;
    end else fifo_full = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    compare_all();
    if (wr_en) wr_pulses++;
    respond();
  endtask

  task automatic send(input logic [7:0] b, input bit pe, input bit fe);
    rx_data = b; parity_error = pe; framing_error = fe; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; parity_error = 1'b0; framing_error = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    model_reset();
    rcnt = 0; fcnt = 0;
    rx_valid = 0; parity_error = 0; framing_error = 0;
    rd_data_valid = 0; fifo_full = 0;
    tick(); tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic wait_tx(input int limit);
    for (int i = 0; i < limit && !tx_wr; i++) tick();
    chk("tx_wr_seen", 32'(tx_wr), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    RST = 1'b0; rx_data = 0; rx_valid = 0; parity_error = 0; framing_error = 0;
    rd_data = 0; rd_data_valid = 0; fifo_full = 0;
    #2;
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_busy",    32'(busy),    0);
    do_reset();

    // Back-to-back write frame.
    base = wr_pulses;
    send(8'hAA, 0, 0); send(8'h05, 0, 0); send(8'h3C, 0, 0);
    chk("w_en",   32'(wr_en),   1);
    chk("w_addr", 32'(addr),    5);
    chk("w_data", 32'(wr_data), 32'h3C);
    repeat (3) tick();
    chk("w_pulses", 32'(wr_pulses - base), 1);
    chk("w_err",    32'(err_cnt), 0);

    // Read with 3-cycle register-file latency.
    fixed_ret = 1; ret_val = 8'h7E; rd_lat = 3;
    send(8'hBB, 0, 0); send(8'h13, 0, 0);
    chk("r_en",   32'(rd_en), 1);
    chk("r_addr", 32'(addr),  3);
    wait_tx(20);
    chk("r_tx_data", 32'(tx_data), 32'h7E);
    tick();

    // Read held off by a full TX FIFO for 10 cycles.
    ret_val = 8'hC5; ff_len = 10;
    send(8'hBB, 0, 0); send(8'h0A, 0, 0);
    wait_tx(40);
    chk("ff_latency", 32'(cyc - dv_cyc), 11);
    chk("ff_tx_data", 32'(tx_data), 32'hC5);
    ff_len = 0;
    tick();

    // Parity error aborts a write, then a clean write follows.
    do_reset();
    base = wr_pulses;
    send(8'hAA, 0, 0); send(8'h02, 0, 0); send(8'h99, 1, 0);
    tick();
    chk("pe_pulses", 32'(wr_pulses - base), 0);
    chk("pe_err",    32'(err_cnt), 1);
    chk("pe_busy",   32'(busy), 0);
    send(8'hAA, 0, 0); send(8'h02, 0, 0); send(8'h11, 0, 0);
    chk("pe_w_en",   32'(wr_en), 1);
    chk("pe_w_addr", 32'(addr), 2);
    chk("pe_w_data", 32'(wr_data), 32'h11);
    tick();

    // Garbage byte then asynchronous reset mid-frame.
    do_reset();
    send(8'h55, 0, 0);
    tick();
    chk("g_err", 32'(err_cnt), 1);
    base = wr_pulses;
    send(8'hAA, 0, 0); send(8'h07, 0, 0);
    #3;
    RST = 1'b0;
    model_reset();
    rcnt = 0; fcnt = 0;
    #1;
    chk("ar_err",  32'(err_cnt), 0);
    chk("ar_addr", 32'(addr), 0);
    chk("ar_busy", 32'(busy), 0);
    tick(); tick();
    RST = 1'b1;
    repeat (4) tick();
    chk("ar_pulses", 32'(wr_pulses - base), 0);

    // Saturation of the error counter.
    do_reset();
    for (int i = 0; i < 300; i++) send(8'($urandom), 0, 1);
    tick();
    chk("sat_err", 32'(err_cnt), 255);

    // Randomized traffic.
    do_reset();
    fixed_ret = 0; rand_full = 1; spurious = 1;
    for (int i = 0; i < 2500; i++) begin
      int r;
      rd_lat = $urandom_range(1, 6);
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 2) != 0) begin
        rx_valid = 1'b1;
        rx_data = (r < 4) ? 8'hAA : (r < 6) ? 8'hBB : 8'($urandom);
        parity_error  = ($urandom_range(0, 29) == 0);
        framing_error = ($urandom_range(0, 29) == 0);
      end else begin
        rx_valid = 0; parity_error = 0; framing_error = 0;
      end
      tick();
    end
    rx_valid = 0; parity_error = 0; framing_error = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-level command decoder on the receive side of the UART link. It consumes the parallel byte stream and error flags from the UART receiver and turns write/read command frames into single-cycle register-file strobes. Read results are pushed back as one byte into the transmit FIFO that feeds the UART transmitter. It sits between `UART_TOP` (RX_OUT/DATA_VALID side, TX FIFO side) and the system register file.

## Interface
- `ADDR_WIDTH`, 4, register-file address width; address taken from the low bits of the address byte
- `DATA_WIDTH`, 8, byte width of the RX/TX path and register data
- `WR_CMD`, 8'hAA, command byte that opens a write frame: CMD, ADDR, DATA
- `RD_CMD`, 8'hBB, command byte that opens a read frame: CMD, ADDR
- `CLK`  in  1  system clock; all logic rising-edge
- `RST`  in  1  asynchronous, active-low reset
- `rx_data`  in  DATA_WIDTH  received byte; valid only when `rx_valid`=1
- `rx_valid`  in  1  single-cycle pulse per received byte
- `parity_error`  in  1  qualifies the current `rx_valid` byte as bad
- `framing_error`  in  1  qualifies the current `rx_valid` byte as bad
- `rd_data`  in  DATA_WIDTH  register-file read data
- `rd_data_valid`  in  1  register-file read data strobe
- `fifo_full`  in  1  TX FIFO cannot accept a byte
- `wr_en`  out  1  register write strobe, one cycle
- `rd_en`  out  1  register read strobe, one cycle
- `addr`  out  ADDR_WIDTH  register address, held from the ADDR byte until the next ADDR byte
- `wr_data`  out  DATA_WIDTH  register write data, held until the next write frame
- `tx_data`  out  DATA_WIDTH  byte pushed to the TX FIFO
- `tx_wr`  out  1  TX FIFO write strobe, one cycle
- `err_cnt`  out  8  saturating count of dropped or bad bytes
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_REQ, RD_WAIT, RD_SEND.
- A byte is **good** when `rx_valid`=1 and both `parity_error` and `framing_error` are 0. A byte is **bad** when `rx_valid`=1 and either error flag is 1.
- IDLE:
  - good `WR_CMD` -> WR_ADDR
  - good `RD_CMD` -> RD_ADDR
  - any other good byte: ignored, `err_cnt`+1
- WR_ADDR: on a good byte, latch `addr`=rx_data[ADDR_WIDTH-1:0] (upper bits are discarded) -> WR_DATA.
- WR_DATA: on a good byte, latch `wr_data` -> WR_EXEC.
- WR_EXEC: assert `wr_en` for one cycle -> IDLE.
- RD_ADDR: on a good byte, latch `addr` -> RD_REQ.
- RD_REQ: assert `rd_en` for one cycle -> RD_WAIT.
- RD_WAIT: on `rd_data_valid`, latch `tx_data`=rd_data -> RD_SEND.
- RD_SEND: when `fifo_full`=0, assert `tx_wr` for one cycle -> IDLE. Otherwise hold in RD_SEND with `tx_data` stable.
- A bad byte in any state: abort the frame -> IDLE, `err_cnt`+1, no strobes issued. In IDLE a bad byte only increments `err_cnt`.
- A byte arriving in WR_EXEC, RD_REQ, RD_WAIT or RD_SEND: dropped, `err_cnt`+1, state unaffected.
- `err_cnt` saturates at 255 and is cleared only by reset.
- `rd_data_valid` outside RD_WAIT is ignored.

## Timing
- Reset, asynchronous assert: state=IDLE; `wr_en`, `rd_en`, `tx_wr` and `busy` = 0; `addr`, `wr_data`, `tx_data` and `err_cnt` = 0.
- Reset release is synchronous to `CLK`. Reset mid-frame discards the frame and issues no strobe.
- Write: `wr_en` is high in cycle N+1, where the DATA byte's `rx_valid` is at cycle N. `addr` and `wr_data` are valid in that same cycle.
- Read: `rd_en` is high in cycle N+1, where the ADDR byte's `rx_valid` is at cycle N. Register-file latency is unbounded; the FSM waits in RD_WAIT with no timeout.
- Read return: `tx_wr` is high no earlier than 1 cycle after `rd_data_valid`, and is delayed while `fifo_full`=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The next frame may start in the cycle the FSM returns to IDLE. Back-to-back `rx_valid` in consecutive cycles must be accepted.

## Test plan
- Write frame AA, 05, 3C (all good) -> exactly one `wr_en` pulse with `addr`=5 and `wr_data`=8'h3C, one cycle after the third `rx_valid`; `err_cnt`=0.
- Read frame BB, 13 with `rd_data`=8'h7E returned 3 cycles after `rd_en` -> `rd_en` with `addr`=4'h3, then `tx_wr` with `tx_data`=8'h7E.
- Read with `fifo_full` held high for 10 cycles after `rd_data_valid` -> `tx_wr` asserted in the first cycle after `fifo_full` falls; `tx_data` stable throughout.
- Byte stream AA, 02, then a data byte with `parity_error`=1 -> no `wr_en`, FSM back to IDLE, `err_cnt`=1. A following frame AA, 02, 11 -> write of 8'h11 to address 2.
- Garbage byte 55 in IDLE, then `RST` asserted low mid-way through an AA frame -> `err_cnt`=1 before reset; after reset all outputs are 0 and no strobe occurs.
- 300 bytes with `framing_error`=1 -> `err_cnt` saturates at 255.
